// File: rtl/present_cipher_core_if.sv
// Handshake bundle for the PRESENT cipher core: block in, block out, status.
interface present_cipher_core_if #(
  parameter int KEY_SIZE = 80
);

  logic                in_valid;
  logic                in_ready;
  logic                mode;
  logic [KEY_SIZE-1:0] key;
  logic [63:0]         data_in;
  logic                out_valid;
  logic                out_ready;
  logic [63:0]         data_out;
  logic                busy;

  modport master (
    output in_valid, mode, key, data_in, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  in_valid, mode, key, data_in, out_ready,
    output in_ready, out_valid, data_out, busy
  );

endinterface

// File: rtl/present_cipher_core.sv
// Iterative PRESENT block cipher: one round per clock, round keys derived on the fly.
// Decrypt first runs the key schedule forward to K32, then walks it back one step per round.
module present_cipher_core #(
  parameter int KEY_SIZE = 80,
  parameter int ROUNDS   = 31
) (
  input logic                  Clock,
  input logic                  Reset,
  present_cipher_core_if.slave bus
);

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_e;

  localparam logic [4:0] LAST_RC = 5'(ROUNDS);

  state_e              state_q, state_d;
  logic [63:0]         data_q, data_d;
  logic [KEY_SIZE-1:0] key_q, key_d;
  logic [4:0]          rc_q, rc_d;
  logic                mode_q, mode_d;
  logic [63:0]         data_out_q, data_out_d;

  logic [63:0]         round_key;
  logic [63:0]         add_w;
  logic [63:0]         sub_w;
  logic [63:0]         enc_w;
  logic [63:0]         iperm_w;
  logic [63:0]         dec_w;
  logic [KEY_SIZE-1:0] key_fwd_w;
  logic [KEY_SIZE-1:0] key_inv_w;
  logic                round_last;

  if (!(KEY_SIZE == 80 || KEY_SIZE == 128)) begin : g_bad_key_size
    $error("present_cipher_core: KEY_SIZE must be 80 or 128");
  end

  if (ROUNDS != 31) begin : g_bad_rounds
    $error("present_cipher_core: ROUNDS must be 31");
  end

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: inv_sbox = 4'h5;  4'h1: inv_sbox = 4'hE;  4'h2: inv_sbox = 4'hF;  4'h3: inv_sbox = 4'h8;
      4'h4: inv_sbox = 4'hC;  4'h5: inv_sbox = 4'h1;  4'h6: inv_sbox = 4'h2;  4'h7: inv_sbox = 4'hD;
      4'h8: inv_sbox = 4'hB;  4'h9: inv_sbox = 4'h4;  4'hA: inv_sbox = 4'h6;  4'hB: inv_sbox = 4'h3;
      4'hC: inv_sbox = 4'h0;  4'hD: inv_sbox = 4'h7;  4'hE: inv_sbox = 4'h9;  default: inv_sbox = 4'hA;
    endcase
  endfunction

  // The round key is always the top 64 bits of the live key register.
  assign round_key = key_q[KEY_SIZE-1 -: 64];
  assign add_w     = data_q ^ round_key;

  // Nibble-wise substitution: forward for encrypt, inverse after the inverse permutation for decrypt.
  for (genvar n = 0; n < 16; n++) begin : g_sbox_layer
    assign sub_w[4*n +: 4] = sbox(add_w[4*n +: 4]);
    assign dec_w[4*n +: 4] = inv_sbox(iperm_w[4*n +: 4]);
  end

  // Bit permutation: bit i moves to 16*i mod 63, bit 63 stays put.
  for (genvar i = 0; i < 64; i++) begin : g_perm_layer
    localparam int DST = (i == 63) ? 63 : (i * 16) % 63;
    assign enc_w[DST]  = sub_w[i];
    assign iperm_w[i]  = add_w[DST];
  end

  if (KEY_SIZE == 80) begin : g_key80
    logic [79:0] inv_t;

    // One forward and one inverse 80-bit key-schedule step for the current round counter.
    always_comb begin
      key_fwd_w         = {key_q[18:0], key_q[79:19]};
      key_fwd_w[79:76]  = sbox(key_fwd_w[79:76]);
      key_fwd_w[19:15]  = key_fwd_w[19:15] ^ rc_q;
      inv_t             = key_q;
      inv_t[19:15]      = inv_t[19:15] ^ rc_q;
      inv_t[79:76]      = inv_sbox(inv_t[79:76]);
      key_inv_w         = {inv_t[60:0], inv_t[79:61]};
    end
  end else if (KEY_SIZE == 128) begin : g_key128
    logic [127:0] inv_t;

    // One forward and one inverse 128-bit key-schedule step for the current round counter.
    always_comb begin
      key_fwd_w           = {key_q[66:0], key_q[127:67]};
      key_fwd_w[127:124]  = sbox(key_fwd_w[127:124]);
      key_fwd_w[123:120]  = sbox(key_fwd_w[123:120]);
      key_fwd_w[66:62]    = key_fwd_w[66:62] ^ rc_q;
      inv_t               = key_q;
      inv_t[66:62]        = inv_t[66:62] ^ rc_q;
      inv_t[127:124]      = inv_sbox(inv_t[127:124]);
      inv_t[123:120]      = inv_sbox(inv_t[123:120]);
      key_inv_w           = {inv_t[60:0], inv_t[127:61]};
    end
  end

  assign round_last = mode_q ? (rc_q == 5'd1) : (rc_q == LAST_RC);

  // FSM state register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = bus.mode ? KEYEXP : ROUND;
      KEYEXP:  if (rc_q == LAST_RC) state_d = ROUND;
      ROUND:   if (round_last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: one transaction at a time, result visible only in DONE.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.busy      = (state_q != IDLE);
    bus.out_valid = (state_q == DONE);
  end

  assign bus.data_out = data_out_q;

  // Datapath next values: capture on accept, key expansion, and one cipher round per cycle.
  always_comb begin
    data_d     = data_q;
    key_d      = key_q;
    rc_d       = rc_q;
    mode_d     = mode_q;
    data_out_d = data_out_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d = bus.data_in;
          key_d  = bus.key;
          rc_d   = 5'd1;
          mode_d = bus.mode;
        end
      end
      KEYEXP: begin
        key_d = key_fwd_w;
        rc_d  = (rc_q == LAST_RC) ? LAST_RC : rc_q + 5'd1;
      end
      ROUND: begin
        if (!mode_q) begin
          data_d = enc_w;
          key_d  = key_fwd_w;
          if (round_last) data_out_d = enc_w ^ key_fwd_w[KEY_SIZE-1 -: 64];
          else            rc_d       = rc_q + 5'd1;
        end else begin
          data_d = dec_w;
          key_d  = key_inv_w;
          if (round_last) data_out_d = dec_w ^ key_inv_w[KEY_SIZE-1 -: 64];
          else            rc_d       = rc_q - 5'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset wipes any block in flight.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      data_q     <= '0;
      key_q      <= '0;
      rc_q       <= '0;
      mode_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      data_q     <= data_d;
      key_q      <= key_d;
      rc_q       <= rc_d;
      mode_q     <= mode_d;
      data_out_q <= data_out_d;
    end
  end

endmodule

// File: tb/tb_present_cipher_core.sv
// Self-checking bench for present_cipher_core: known vectors, handshake corners, random round trips.
module tb_present_cipher_core;

  typedef struct {
    bit          wide;
    bit          dec;
    logic [127:0] key;
    logic [63:0] din;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  localparam logic [127:0] MASK80 = (128'd1 << 80) - 128'd1;

  logic         Clock;
  logic         Reset;
  logic         tb_in_valid, tb_mode, tb_out_ready, sel128;
  logic [127:0] tb_key;
  logic [63:0]  tb_data;
  logic         in_ready_m, out_valid_m, busy_m;
  logic [63:0]  data_out_m;
  int           n_checks;
  int           n_errors;
  vec_t         vecs [5];

  present_cipher_core_if #(.KEY_SIZE(80))  bus80 ();
  present_cipher_core_if #(.KEY_SIZE(128)) bus128 ();

  assign bus80.in_valid   = tb_in_valid & ~sel128;
  assign bus80.mode       = tb_mode;
  assign bus80.key        = tb_key[79:0];
  assign bus80.data_in    = tb_data;
  assign bus80.out_ready  = tb_out_ready & ~sel128;
  assign bus128.in_valid  = tb_in_valid & sel128;
  assign bus128.mode      = tb_mode;
  assign bus128.key       = tb_key;
  assign bus128.data_in   = tb_data;
  assign bus128.out_ready = tb_out_ready & sel128;

  assign in_ready_m  = sel128 ? bus128.in_ready  : bus80.in_ready;
  assign out_valid_m = sel128 ? bus128.out_valid : bus80.out_valid;
  assign busy_m      = sel128 ? bus128.busy      : bus80.busy;
  assign data_out_m  = sel128 ? bus128.data_out  : bus80.data_out;

  present_cipher_core #(.KEY_SIZE(80)) dut80 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus80)
  );

  present_cipher_core #(.KEY_SIZE(128)) dut128 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus128)
  );

  always #5 Clock = ~Clock;

  function automatic int perm_dst(input int i);
    return (i == 63) ? 63 : (16 * i) % 63;
  endfunction

  // Reference PRESENT: expands all 32 round keys up front, then runs the rounds forwards or backwards.
  function automatic logic [63:0] ref_cipher(input bit dec, input bit wide,
                                             input logic [127:0] key_in, input logic [63:0] blk);
    logic [3:0]   sb  [16];
    logic [3:0]   isb [16];
    logic [63:0]  rk  [33];
    logic [127:0] k;
    logic [63:0]  s;
    logic [63:0]  t;
    sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    for (int v = 0; v < 16; v++) isb[sb[4'(v)]] = 4'(v);
    rk[0] = '0;
    k = wide ? key_in : (key_in & MASK80);
    for (int r = 1; r <= 32; r++) begin
      rk[6'(r)] = wide ? k[127:64] : k[79:16];
      if (r < 32) begin
        if (wide) begin
          k = (k << 61) | (k >> 67);
          k[127:124] = sb[k[127:124]];
          k[123:120] = sb[k[123:120]];
          k[66:62]   = k[66:62] ^ 5'(r);
        end else begin
          k = ((k << 61) | (k >> 19)) & MASK80;
          k[79:76] = sb[k[79:76]];
          k[19:15] = k[19:15] ^ 5'(r);
        end
      end
    end
    if (!dec) begin
      s = blk;
      for (int r = 1; r <= 31; r++) begin
        s = s ^ rk[6'(r)];
        for (int j = 0; j < 16; j++) s[6'(4*j) +: 4] = sb[s[6'(4*j) +: 4]];
        t = '0;
        for (int i = 0; i < 64; i++) t[6'(perm_dst(i))] = s[6'(i)];
        s = t;
      end
      s = s ^ rk[32];
    end else begin
      s = blk ^ rk[32];
      for (int r = 31; r >= 1; r--) begin
        t = '0;
        for (int i = 0; i < 64; i++) t[6'(i)] = s[6'(perm_dst(i))];
        s = t;
        for (int j = 0; j < 16; j++) s[6'(4*j) +: 4] = isb[s[6'(4*j) +: 4]];
        s = s ^ rk[6'(r)];
      end
    end
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit dec, input logic [127:0] k, input logic [63:0] d, input bit hold);
    @(negedge Clock);
    checkOutput("in_ready_before_accept", 64'(in_ready_m), 64'd1);
    tb_in_valid  = 1'b1;
    tb_mode      = dec;
    tb_key       = k;
    tb_data      = d;
    tb_out_ready = hold;
    @(posedge Clock);
    #1;
    tb_in_valid = 1'b0;
    tb_mode     = 1'($urandom);
    tb_key      = {$urandom, $urandom, $urandom, $urandom};
    tb_data     = {$urandom, $urandom};
    checkOutput("busy_after_accept", 64'(busy_m), 64'd1);
    checkOutput("in_ready_after_accept", 64'(in_ready_m), 64'd0);
  endtask

  task automatic waitOutput(output int lat);
    lat = 0;
    while (out_valid_m !== 1'b1 && lat < 200) begin
      @(posedge Clock);
      #1;
      lat++;
    end
    checkOutput("out_valid_within_bound", 64'(out_valid_m), 64'd1);
  endtask

  task automatic releaseOutput();
    if (tb_out_ready !== 1'b1) begin
      @(negedge Clock);
      tb_out_ready = 1'b1;
    end
    @(posedge Clock);
    #1;
    checkOutput("out_valid_after_handshake", 64'(out_valid_m), 64'd0);
    checkOutput("in_ready_after_handshake", 64'(in_ready_m), 64'd1);
    tb_out_ready = 1'b0;
  endtask

  task automatic runTxn(input bit dec, input logic [127:0] k, input logic [63:0] d, input bit hold,
                        output logic [63:0] res, output int lat);
    applyStimulus(dec, k, d, hold);
    waitOutput(lat);
    res = data_out_m;
    releaseOutput();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached before the test completed");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] k;
    logic [63:0]  d, r1, r2, expv;
    int           lat;
    bit           first_dec;

    Clock = 1'b0; Reset = 1'b0;
    tb_in_valid = 1'b0; tb_mode = 1'b0; tb_out_ready = 1'b0; sel128 = 1'b0;
    tb_key = '0; tb_data = '0;
    n_checks = 0; n_errors = 0;

    vecs[0] = '{1'b0, 1'b0, 128'h0, 64'h0, 64'h5579C1387B228445, 31};
    vecs[1] = '{1'b0, 1'b0, 128'hFFFF_FFFFFFFF_FFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h3333DCD3213210D2, 31};
    vecs[2] = '{1'b0, 1'b1, 128'h0, 64'hA112FFC72F68417B, 64'hFFFFFFFFFFFFFFFF, 62};
    vecs[3] = '{1'b0, 1'b1, 128'hFFFF_FFFFFFFF_FFFFFFFF, 64'hE72C46C0F5945049, 64'h0, 62};
    vecs[4] = '{1'b1, 1'b0, 128'h0, 64'h0, 64'h96DB702A2E6900AF, 31};

    $display("[TB] reset state");
    repeat (3) @(posedge Clock);
    #1;
    checkOutput("rst80_in_ready",   64'(bus80.in_ready),   64'd1);
    checkOutput("rst80_out_valid",  64'(bus80.out_valid),  64'd0);
    checkOutput("rst80_busy",       64'(bus80.busy),       64'd0);
    checkOutput("rst80_data_out",   bus80.data_out,        64'd0);
    checkOutput("rst128_in_ready",  64'(bus128.in_ready),  64'd1);
    checkOutput("rst128_out_valid", 64'(bus128.out_valid), 64'd0);
    checkOutput("rst128_busy",      64'(bus128.busy),      64'd0);
    checkOutput("rst128_data_out",  bus128.data_out,       64'd0);
    @(negedge Clock);
    Reset = 1'b1;

    $display("[TB] known-answer vectors");
    for (int i = 0; i < 5; i++) begin
      sel128 = vecs[i].wide;
      runTxn(vecs[i].dec, vecs[i].key, vecs[i].din, 1'b0, r1, lat);
      checkOutput($sformatf("vec%0d_data", i), r1, vecs[i].exp);
      checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    sel128 = 1'b1;
    runTxn(1'b1, 128'h0, 64'h96DB702A2E6900AF, 1'b0, r1, lat);
    checkOutput("k128_decrypt_data", r1, 64'h0);
    checkOutput("k128_decrypt_latency", 64'(lat), 64'd62);
    sel128 = 1'b0;

    $display("[TB] back-pressure");
    k = {$urandom, $urandom, $urandom, $urandom};
    d = {$urandom, $urandom};
    expv = ref_cipher(1'b0, 1'b0, k, d);
    applyStimulus(1'b0, k, d, 1'b0);
    waitOutput(lat);
    checkOutput("bp_latency", 64'(lat), 64'd31);
    for (int c = 0; c < 20; c++) begin
      @(negedge Clock);
      tb_in_valid = (c % 4 == 1);
      tb_data     = ~d;
      tb_mode     = 1'b0;
      @(posedge Clock);
      #1;
      checkOutput("bp_data_stable", data_out_m, expv);
      checkOutput("bp_out_valid", 64'(out_valid_m), 64'd1);
      checkOutput("bp_in_ready", 64'(in_ready_m), 64'd0);
    end
    tb_in_valid = 1'b0;
    releaseOutput();
    repeat (3) @(posedge Clock);
    #1;
    checkOutput("bp_nothing_queued", 64'(busy_m), 64'd0);
    checkOutput("bp_data_out_held", data_out_m, expv);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b0, 128'h0, 64'h0, 1'b0);
    repeat (14) @(posedge Clock);
    #1;
    Reset = 1'b0;
    #1;
    checkOutput("midrst_in_ready",  64'(bus80.in_ready),  64'd1);
    checkOutput("midrst_out_valid", 64'(bus80.out_valid), 64'd0);
    checkOutput("midrst_busy",      64'(bus80.busy),      64'd0);
    checkOutput("midrst_data_out",  bus80.data_out,       64'd0);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (40) @(posedge Clock);
    #1;
    checkOutput("midrst_no_output", 64'(out_valid_m), 64'd0);
    checkOutput("midrst_idle",      64'(busy_m),      64'd0);
    runTxn(1'b0, 128'h0, 64'h0, 1'b0, r1, lat);
    checkOutput("midrst_recover_data", r1, 64'h5579C1387B228445);
    checkOutput("midrst_recover_latency", 64'(lat), 64'd31);

    $display("[TB] random regression");
    for (int i = 0; i < 500; i++) begin
      sel128    = 1'($urandom);
      first_dec = 1'($urandom);
      k = {$urandom, $urandom, $urandom, $urandom};
      d = {$urandom, $urandom};
      runTxn(first_dec, k, d, 1'($urandom), r1, lat);
      checkOutput($sformatf("rand%0d_model", i), r1, ref_cipher(first_dec, sel128, k, d));
      checkOutput($sformatf("rand%0d_latency", i), 64'(lat), first_dec ? 64'd62 : 64'd31);
      runTxn(~first_dec, k, r1, 1'($urandom), r2, lat);
      checkOutput($sformatf("rand%0d_roundtrip", i), r2, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
